q_update_ctrl: RTL and testbench
================================

Q_UPDATE_CTRL -- requirements
Module: q_update_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- FIFO_DEPTH, 4, request FIFO entries, power of two.
- RD_LAT, 2, cycles from address presentation to valid dp_q_new (RAM read plus delay stage).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, sole clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- cfg_load, in, 1, load cfg_gamma/cfg_alfa into shadow registers.
- cfg_gamma, in, 16, discount factor.
- cfg_alfa, in, 16, learning rate.
- req_valid, in, 1, transition request offered.
- req_ready, out, 1, FIFO not full.
- req_state, in, 18, current state s.
- req_next_state, in, 18, next state s'.
- req_action, in, 4, action a; legal range 0..8.
- req_reward, in, 16, reward r.
- dp_state, out, 18, datapath write address.
- dp_next_state, out, 18, datapath read address.
- dp_action, out, 4, datapath action select.
- dp_reward, out, 16, datapath reward.
- dp_gamma, out, 16, datapath gamma.
- dp_alfa, out, 16, datapath alfa.
- dp_wr_en, out, 1, qualifies Q-table write of dp_q_new.
- dp_q_new, in, 16, updated Q value from datapath.
- upd_done, out, 1, one-cycle pulse per completed update.
- upd_q, out, 16, Q value written, valid with upd_done.
- err_action, out, 1, one-cycle pulse on dropped illegal action.
- busy, out, 1, FSM not IDLE or FIFO not empty.
- upd_count, out, 16, completed-update counter.

Function
REQ-003 Request accepted on rising clock edge with req_valid && req_ready; all five req_* fields SHALL be pushed as one FIFO entry.
REQ-004 req_ready SHALL be low exactly when FIFO holds FIFO_DEPTH entries; push while full SHALL be ignored without corrupting entries.
REQ-005 Simultaneous push and pop while full SHALL be rejected (req_ready low), pop proceeds; push and pop while non-full SHALL both occur, count unchanged.
REQ-006 FSM states SHALL be IDLE, FETCH, WRITE, DONE.
REQ-007 IDLE: if FIFO non-empty, pop head into working registers; legal action -> FETCH next cycle; action 9..15 -> pulse err_action, no write, remain IDLE.
REQ-008 FETCH: dp_state, dp_next_state, dp_action, dp_reward SHALL hold working registers; FSM SHALL stay exactly RD_LAT cycles, then go to WRITE.
REQ-009 WRITE: dp_wr_en SHALL be high for exactly one cycle, addresses/action unchanged; dp_q_new SHALL be captured into upd_q; next state DONE.
REQ-010 DONE: upd_done pulses one cycle, upd_count increments (wraps 16'hFFFF->0); next state IDLE.
REQ-011 Pop-to-upd_done latency SHALL be RD_LAT+2 cycles; back-to-back updates SHALL issue every RD_LAT+3 cycles.
REQ-012 dp_wr_en SHALL be low in all states except WRITE.
REQ-013 cfg_load SHALL update dp_gamma/dp_alfa only in IDLE; cfg_load outside IDLE SHALL be held pending and applied on IDLE entry, preserving values for in-flight update.
REQ-014 Updates SHALL complete in FIFO order, one at a time; no overlap of two transitions in datapath.

Reset
REQ-015 reset_n low SHALL immediately force IDLE, FIFO empty, req_ready high, dp_wr_en/upd_done/err_action low, busy low, upd_count 0, upd_q 0, dp_* 0, pending cfg cleared.
REQ-016 Reset during FETCH or WRITE SHALL abort update with no write completed after reset assertion and no upd_done.

Verification
REQ-017 Single update: cfg gamma=16'h0E66, alfa=16'h0199; push s=5, s'=9, a=3, r=16'h0100 -> dp_wr_en one cycle at pop+RD_LAT+1, upd_done at pop+4, upd_count=1.
REQ-018 Fill: push 5 with req_valid held, no pops possible -> 4 accepted, req_ready low on 5th; outputs in FIFO order.
REQ-019 Illegal action: push a=4'hB -> err_action pulse, dp_wr_en never high, upd_count unchanged, next entry processed.
REQ-020 Back-to-back: 3 queued legal requests -> upd_done spacing exactly 5 cycles (RD_LAT=2).
REQ-021 cfg_load during FETCH with gamma=16'h0800 -> dp_gamma unchanged until IDLE, then 16'h0800.
REQ-022 reset_n low in FETCH -> dp_wr_en stays low, FIFO empty, upd_count 0, busy low.

Source files
------------

// File: rtl/q_update_ctrl.sv
// q_update_ctrl: sequences Q-learning table updates.
// Transition requests are queued in a small FIFO. They are then issued to an
// external read/modify/write datapath one at a time, in arrival order.
//
// Handshake: a request transfers on the rising clock edge where
// req_valid && req_ready. req_ready depends only on FIFO occupancy, never on
// req_valid. While the FIFO is full, a push is refused even if a pop happens
// on the same edge.
//
// Per-update sequence: IDLE (pop) -> FETCH (RD_LAT cycles) -> WRITE -> DONE.
module q_update_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int RD_LAT     = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cfg_load,
   input  logic [15:0] cfg_gamma,
   input  logic [15:0] cfg_alfa,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [17:0] req_state,
   input  logic [17:0] req_next_state,
   input  logic [3:0]  req_action,
   input  logic [15:0] req_reward,
   output logic [17:0] dp_state,
   output logic [17:0] dp_next_state,
   output logic [3:0]  dp_action,
   output logic [15:0] dp_reward,
   output logic [15:0] dp_gamma,
   output logic [15:0] dp_alfa,
   output logic        dp_wr_en,
   input  logic [15:0] dp_q_new,
   output logic        upd_done,
   output logic [15:0] upd_q,
   output logic        err_action,
   output logic        busy,
   output logic [15:0] upd_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state_q;

   // FIFO entry layout: {state[55:38], next_state[37:20], action[19:16], reward[15:0]}
   logic [55:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push;
   logic          pop;
   logic [55:0]   head;
   logic          head_legal;

   // Working registers, which drive the datapath directly
   logic [17:0]   cur_state_q;
   logic [17:0]   nxt_state_q;
   logic [3:0]    act_q;
   logic [15:0]   rew_q;
   logic [LW-1:0] lat_cnt_q;
   logic          dp_wr_en_q;
   logic          upd_done_q;
   logic          err_action_q;
   logic [15:0]   upd_q_q;
   logic [15:0]   upd_count_q;

   // Configuration shadow plus a pending slot for loads that arrive mid-update
   logic [15:0]   gamma_q;
   logic [15:0]   alfa_q;
   logic          pend_q;
   logic [15:0]   pend_gamma_q;
   logic [15:0]   pend_alfa_q;

   assign req_ready  = (count_q != FULL_CNT);
   assign push       = req_valid && req_ready;
   assign pop        = (state_q == IDLE) && (count_q != '0);
   assign head       = fifo_mem[rd_ptr_q];
   assign head_legal = (head[19:16] <= 4'd8);

   // Next pointer and occupancy values; push and pop together leave the count unchanged
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)
         count_d = count_q + CW'(1);
      else if (!push && pop)
         count_d = count_q - CW'(1);
   end

   // FIFO storage; emptiness is governed by the pointers, so storage needs no reset
   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr_q] <= {req_state, req_next_state, req_action, req_reward};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Update sequencer, with registered strobes and working registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cur_state_q  <= '0;
         nxt_state_q  <= '0;
         act_q        <= '0;
         rew_q        <= '0;
         lat_cnt_q    <= '0;
         dp_wr_en_q   <= 1'b0;
         upd_done_q   <= 1'b0;
         err_action_q <= 1'b0;
         upd_q_q      <= '0;
         upd_count_q  <= '0;
      end else begin
         dp_wr_en_q   <= 1'b0;
         upd_done_q   <= 1'b0;
         err_action_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  if (head_legal) begin
                     cur_state_q <= head[55:38];
                     nxt_state_q <= head[37:20];
                     act_q       <= head[19:16];
                     rew_q       <= head[15:0];
                     lat_cnt_q   <= '0;
                     state_q     <= FETCH;
                  end else begin
                     // Illegal action: the entry is dropped and flagged, and the datapath is left untouched
                     err_action_q <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (lat_cnt_q == LAT_LAST) begin
                  dp_wr_en_q <= 1'b1;
                  state_q    <= WRITE;
               end else begin
                  lat_cnt_q <= lat_cnt_q + LW'(1);
               end
            end
            WRITE: begin
               upd_q_q     <= dp_q_new;
               upd_done_q  <= 1'b1;
               upd_count_q <= upd_count_q + 16'd1;
               state_q     <= DONE;
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Gamma/alfa shadow: loads are taken directly in IDLE and deferred to IDLE entry otherwise
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         gamma_q      <= '0;
         alfa_q       <= '0;
         pend_q       <= 1'b0;
         pend_gamma_q <= '0;
         pend_alfa_q  <= '0;
      end else if (state_q == IDLE) begin
         if (cfg_load) begin
            gamma_q <= cfg_gamma;
            alfa_q  <= cfg_alfa;
         end
      end else if (state_q == DONE) begin
         // The next edge enters IDLE, so a fresh load wins over an older pending one
         if (cfg_load) begin
            gamma_q <= cfg_gamma;
            alfa_q  <= cfg_alfa;
         end else if (pend_q) begin
            gamma_q <= pend_gamma_q;
            alfa_q  <= pend_alfa_q;
         end
         pend_q <= 1'b0;
      end else if (cfg_load) begin
         pend_q       <= 1'b1;
         pend_gamma_q <= cfg_gamma;
         pend_alfa_q  <= cfg_alfa;
      end
   end

   assign dp_state      = cur_state_q;
   assign dp_next_state = nxt_state_q;
   assign dp_action     = act_q;
   assign dp_reward     = rew_q;
   assign dp_gamma      = gamma_q;
   assign dp_alfa       = alfa_q;
   assign dp_wr_en      = dp_wr_en_q;
   assign upd_done      = upd_done_q;
   assign upd_q         = upd_q_q;
   assign err_action    = err_action_q;
   assign upd_count     = upd_count_q;
   assign busy          = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_q_update_ctrl.sv
// tb_q_update_ctrl: directed bench for q_update_ctrl.
// The datapath stand-in returns next_state[15:0] + reward + action only while dp_wr_en is high.
// Expected Q values below are hand-computed from that rule.
module tb_q_update_ctrl;

   logic        clock;
   logic        reset_n;
   logic        cfg_load;
   logic [15:0] cfg_gamma;
   logic [15:0] cfg_alfa;
   logic        req_valid;
   logic        req_ready;
   logic [17:0] req_state;
   logic [17:0] req_next_state;
   logic [3:0]  req_action;
   logic [15:0] req_reward;
   logic [17:0] dp_state;
   logic [17:0] dp_next_state;
   logic [3:0]  dp_action;
   logic [15:0] dp_reward;
   logic [15:0] dp_gamma;
   logic [15:0] dp_alfa;
   logic        dp_wr_en;
   logic [15:0] dp_q_new;
   logic        upd_done;
   logic [15:0] upd_q;
   logic        err_action;
   logic        busy;
   logic [15:0] upd_count;

   int          total;
   int          bad;
   int          cyc;
   int          wr_cnt;
   int          err_cnt;
   int          done_cyc[$];
   logic [15:0] exp_q[$];
   logic        prev_wr;

   q_update_ctrl #(.FIFO_DEPTH(4), .RD_LAT(2)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .cfg_load       (cfg_load),
      .cfg_gamma      (cfg_gamma),
      .cfg_alfa       (cfg_alfa),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_state      (req_state),
      .req_next_state (req_next_state),
      .req_action     (req_action),
      .req_reward     (req_reward),
      .dp_state       (dp_state),
      .dp_next_state  (dp_next_state),
      .dp_action      (dp_action),
      .dp_reward      (dp_reward),
      .dp_gamma       (dp_gamma),
      .dp_alfa        (dp_alfa),
      .dp_wr_en       (dp_wr_en),
      .dp_q_new       (dp_q_new),
      .upd_done       (upd_done),
      .upd_q          (upd_q),
      .err_action     (err_action),
      .busy           (busy),
      .upd_count      (upd_count)
   );

   assign dp_q_new = dp_wr_en ? (dp_next_state[15:0] + dp_reward + {12'h000, dp_action}) : 16'hBAD0;

   // clock and cycle counter
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Presents one request and holds req_valid until it is accepted; waited counts the stalled cycles
   task automatic offer(input logic [17:0] s, input logic [17:0] ns, input logic [3:0] a,
                        input logic [15:0] r, output int waited);
      req_state      = s;
      req_next_state = ns;
      req_action     = a;
      req_reward     = r;
      req_valid      = 1'b1;
      waited         = 0;
      while (!req_ready && waited < 50) begin
         @(posedge clock);
         #1;
         waited++;
      end
      if (waited >= 50) check("offer_timeout", 32'(req_ready), 32'd1);
      else begin
         @(posedge clock);
         #1;
      end
      req_valid = 1'b0;
   endtask

   task automatic push(input logic [17:0] s, input logic [17:0] ns, input logic [3:0] a,
                       input logic [15:0] r);
      int w;
      offer(s, ns, a, r, w);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         step(1);
         n++;
      end
      check("idle_reached", 32'(busy), 32'd0);
   endtask

   // scoreboard monitor: checks completions in order and watches write-strobe width
   always @(negedge clock) begin
      if (reset_n) begin
         if (dp_wr_en) begin
            wr_cnt++;
            check("wr_single", 32'(prev_wr), 32'd0);
         end
         if (err_action) err_cnt++;
         if (upd_done) begin
            done_cyc.push_back(cyc);
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("upd_q_order", 32'(upd_q), 32'(exp_q.pop_front()));
         end
      end
      prev_wr = dp_wr_en;
   end

   initial begin
      int w;
      int wsum;
      int wr_b;
      int err_b;
      int base;
      total     = 0;
      bad       = 0;
      cyc       = 0;
      wr_cnt    = 0;
      err_cnt   = 0;
      prev_wr   = 1'b0;
      reset_n   = 1'b0;
      cfg_load  = 1'b0;
      cfg_gamma = '0;
      cfg_alfa  = '0;
      req_valid = 1'b0;
      req_state = '0;
      req_next_state = '0;
      req_action = '0;
      req_reward = '0;

      // reset values
      step(2);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_en", 32'(dp_wr_en), 32'd0);
      check("rst_done", 32'(upd_done), 32'd0);
      check("rst_err", 32'(err_action), 32'd0);
      check("rst_count", 32'(upd_count), 32'd0);
      check("rst_upd_q", 32'(upd_q), 32'd0);
      check("rst_dp_state", 32'(dp_state), 32'd0);
      check("rst_gamma", 32'(dp_gamma), 32'd0);
      reset_n = 1'b1;
      step(1);

      // configuration load in IDLE
      cfg_gamma = 16'h0E66;
      cfg_alfa  = 16'h0199;
      cfg_load  = 1'b1;
      step(1);
      cfg_load = 1'b0;
      check("cfg_gamma_idle", 32'(dp_gamma), 32'h0E66);
      check("cfg_alfa_idle", 32'(dp_alfa), 32'h0199);

      // single update: 9 + 0x100 + 3 = 0x010C
      exp_q.push_back(16'h010C);
      push(18'd5, 18'd9, 4'd3, 16'h0100);
      step(1);
      check("t1_dp_state", 32'(dp_state), 32'd5);
      check("t1_dp_next", 32'(dp_next_state), 32'd9);
      check("t1_dp_action", 32'(dp_action), 32'd3);
      check("t1_dp_reward", 32'(dp_reward), 32'h0100);
      check("t1_fetch_wr0", 32'(dp_wr_en), 32'd0);
      step(1);
      check("t1_fetch2_wr0", 32'(dp_wr_en), 32'd0);
      step(1);
      check("t1_write_wr1", 32'(dp_wr_en), 32'd1);
      check("t1_write_addr", 32'(dp_state), 32'd5);
      step(1);
      check("t1_done_wr0", 32'(dp_wr_en), 32'd0);
      check("t1_done_pulse", 32'(upd_done), 32'd1);
      check("t1_count", 32'(upd_count), 32'd1);
      check("t1_upd_q", 32'(upd_q), 32'h010C);
      step(1);
      check("t1_done_low", 32'(upd_done), 32'd0);
      check("t1_idle_busy", 32'(busy), 32'd0);

      // illegal action is dropped, and the next entry proceeds: 0x100 + 0x200 + 5 = 0x0305
      wr_b  = wr_cnt;
      err_b = err_cnt;
      push(18'd7, 18'h77, 4'hB, 16'h0007);
      exp_q.push_back(16'h0305);
      push(18'd8, 18'h100, 4'd5, 16'h0200);
      check("ill_err_pulse", 32'(err_action), 32'd1);
      check("ill_wr_low", 32'(dp_wr_en), 32'd0);
      step(1);
      check("ill_err_single", 32'(err_action), 32'd0);
      wait_idle();
      check("ill_err_cnt", 32'(err_cnt - err_b), 32'd1);
      check("ill_wr_cnt", 32'(wr_cnt - wr_b), 32'd1);
      check("ill_count", 32'(upd_count), 32'd2);
      check("ill_upd_q", 32'(upd_q), 32'h0305);

      // back-to-back: three queued updates finish five cycles apart
      base = done_cyc.size();
      exp_q.push_back(16'h0002);
      exp_q.push_back(16'h0005);
      exp_q.push_back(16'h0008);
      push(18'd1, 18'd1, 4'd0, 16'h0001);
      push(18'd2, 18'd2, 4'd1, 16'h0002);
      push(18'd3, 18'd3, 4'd2, 16'h0003);
      wait_idle();
      check("b2b_dones", 32'(done_cyc.size() - base), 32'd3);
      if (done_cyc.size() >= base + 3) begin
         check("b2b_gap1", 32'(done_cyc[base+1] - done_cyc[base]), 32'd5);
         check("b2b_gap2", 32'(done_cyc[base+2] - done_cyc[base+1]), 32'd5);
      end
      check("b2b_count", 32'(upd_count), 32'd5);

      // fill: X occupies the sequencer, then A..D fill the FIFO and E must stall
      exp_q.push_back(16'h0012);
      exp_q.push_back(16'h1021);
      exp_q.push_back(16'h2032);
      exp_q.push_back(16'h3048);
      exp_q.push_back(16'h0059);
      exp_q.push_back(16'h0001);
      push(18'd1, 18'd2, 4'd0, 16'h0010);
      wsum = 0;
      offer(18'd10, 18'h20, 4'd1, 16'h1000, w);
      wsum += w;
      offer(18'd11, 18'h30, 4'd2, 16'h2000, w);
      wsum += w;
      offer(18'd12, 18'h40, 4'd8, 16'h3000, w);
      wsum += w;
      offer(18'd13, 18'h50, 4'd4, 16'h0005, w);
      wsum += w;
      check("fill_accept4", 32'(wsum), 32'd0);
      check("fill_full_ready", 32'(req_ready), 32'd0);
      check("fill_busy", 32'(busy), 32'd1);
      offer(18'd14, 18'h3FFFF, 4'd1, 16'h0001, w);
      check("fill_wait", 32'(w), 32'd2);
      wait_idle();
      check("fill_count", 32'(upd_count), 32'd11);
      check("fill_last_q", 32'(upd_q), 32'h0001);

      // cfg_load during FETCH is deferred until IDLE: 0x44 + 0x4000 + 6 = 0x404A
      exp_q.push_back(16'h404A);
      push(18'd20, 18'h44, 4'd6, 16'h4000);
      step(1);
      cfg_gamma = 16'h0800;
      cfg_alfa  = 16'h0333;
      cfg_load  = 1'b1;
      step(1);
      cfg_load = 1'b0;
      check("cfg_hold_fetch", 32'(dp_gamma), 32'h0E66);
      step(1);
      check("cfg_write_wr", 32'(dp_wr_en), 32'd1);
      check("cfg_hold_write", 32'(dp_gamma), 32'h0E66);
      step(1);
      check("cfg_done_pulse", 32'(upd_done), 32'd1);
      check("cfg_hold_done", 32'(dp_gamma), 32'h0E66);
      step(1);
      check("cfg_apply_gamma", 32'(dp_gamma), 32'h0800);
      check("cfg_apply_alfa", 32'(dp_alfa), 32'h0333);
      check("cfg_count", 32'(upd_count), 32'd12);

      // reset while in FETCH, with a pending cfg and a queued entry
      push(18'd30, 18'h31, 4'd2, 16'h0001);
      push(18'd31, 18'h32, 4'd3, 16'h0002);
      cfg_gamma = 16'h1234;
      cfg_load  = 1'b1;
      step(1);
      cfg_load = 1'b0;
      wr_b = wr_cnt;
      base = done_cyc.size();
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_wr_en", 32'(dp_wr_en), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_ready", 32'(req_ready), 32'd1);
      check("ar_count", 32'(upd_count), 32'd0);
      check("ar_upd_q", 32'(upd_q), 32'd0);
      check("ar_dp_state", 32'(dp_state), 32'd0);
      check("ar_gamma", 32'(dp_gamma), 32'd0);
      step(2);
      reset_n = 1'b1;
      step(8);
      check("ar_no_write", 32'(wr_cnt - wr_b), 32'd0);
      check("ar_no_done", 32'(done_cyc.size() - base), 32'd0);
      check("ar_idle_busy", 32'(busy), 32'd0);
      check("ar_count_hold", 32'(upd_count), 32'd0);
      // an update after reset must not pick up the cleared pending cfg
      exp_q.push_back(16'h0010);
      push(18'd40, 18'h10, 4'd0, 16'h0000);
      wait_idle();
      check("ar_post_count", 32'(upd_count), 32'd1);
      check("ar_post_gamma", 32'(dp_gamma), 32'd0);
      check("ar_post_upd_q", 32'(upd_q), 32'h0010);

      step(2);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
